// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: writeback initiator for the 16x16 register file.
// The ALU and load writeback requests are merged into a small in-order queue.
// One queued write is drained per cycle onto the RegisterFile write port.
// The block also provides per-register pending bits and youngest-entry bypass data.
// Optional feature: define WB_RR_ARB_EN for round-robin arbitration of the last free slot.
// Handshake: a request transfers on the rising edge where valid & ready are both 1.
// A ready never depends on the same source's valid, and both readies are 0 while rst=0.
module regfile_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_reg,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [3:0]  mem_reg,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    input  logic        wb_hold,
    output logic [3:0]  rf_DstReg,
    output logic        rf_WriteReg,
    output logic [15:0] rf_DstData,
    input  logic [3:0]  q_reg1,
    input  logic [3:0]  q_reg2,
    output logic        q_hit1,
    output logic        q_hit2,
    output logic [15:0] q_data1,
    output logic [15:0] q_data2,
    output logic [15:0] busy,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    r_reg  [DEPTH];
    logic [15:0]   r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_free;
    logic          w_free_ge2;
    logic          w_free_eq1;
    logic          w_mem_rdy_raw;
    logic          w_alu_rdy_raw;
    logic          w_mem_older;
    logic          w_mem_en;
    logic          w_alu_en;
    logic          w_o_en;
    logic [3:0]    w_o_reg;
    logic [15:0]   w_o_data;
    logic          w_y_en;
    logic [3:0]    w_y_reg;
    logic [15:0]   w_y_data;
    logic [CW-1:0] w_enq_cnt;
    logic          w_deq;
    logic [PW-1:0] w_tail_p1;
    logic [PW-1:0] w_idx;

    // The slot freed by this cycle's drain is not credited to the readies.
    assign w_free     = CW'(DEPTH) - r_count;
    assign w_free_ge2 = (w_free >= CW'(2));
    assign w_free_eq1 = (w_free == CW'(1));

`ifdef WB_RR_ARB_EN
    // 1 = the load source wins the next contested grant and is older when both are accepted.
    logic r_rr_mem;
    logic w_contested;

    assign w_contested   = w_free_eq1 & mem_valid & alu_valid;
    assign w_mem_rdy_raw = w_free_ge2 | (w_free_eq1 & (!alu_valid | r_rr_mem));
    assign w_alu_rdy_raw = w_free_ge2 | (w_free_eq1 & (!mem_valid | !r_rr_mem));
    assign w_mem_older   = r_rr_mem;

    // Flip the round-robin pointer after every contested grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_mem <= 1'b1;
        end else if (w_contested) begin
            r_rr_mem <= !r_rr_mem;
        end
    end
`else
    assign w_mem_rdy_raw = (w_free != '0);
    assign w_alu_rdy_raw = w_free_ge2 | (w_free_eq1 & !mem_valid);
    assign w_mem_older   = 1'b1;
`endif

    assign mem_ready = rst & w_mem_rdy_raw;
    assign alu_ready = rst & w_alu_rdy_raw;

    // An accepted write to R0 completes its handshake but is never queued.
    assign w_mem_en = mem_valid & mem_ready & (mem_reg != 4'd0);
    assign w_alu_en = alu_valid & alu_ready & (alu_reg != 4'd0);

    // Order the two candidates: the older one goes into the queue first.
    assign w_o_en   = w_mem_older ? w_mem_en : w_alu_en;
    assign w_o_reg  = w_mem_older ? mem_reg  : alu_reg;
    assign w_o_data = w_mem_older ? mem_data : alu_data;
    assign w_y_en   = w_mem_older ? w_alu_en : w_mem_en;
    assign w_y_reg  = w_mem_older ? alu_reg  : mem_reg;
    assign w_y_data = w_mem_older ? alu_data : mem_data;

    assign w_enq_cnt = CW'(w_o_en) + CW'(w_y_en);
    assign w_tail_p1 = r_tail + PW'(1);

    assign empty       = (r_count == '0);
    assign w_deq       = !empty & !wb_hold;
    assign rf_WriteReg = w_deq;
    assign rf_DstReg   = w_deq ? r_reg[r_head]  : 4'd0;
    assign rf_DstData  = w_deq ? r_data[r_head] : 16'd0;

    // Queue storage: the older candidate lands at the tail, and the younger one lands after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_reg[i]  <= 4'd0;
                r_data[i] <= 16'd0;
            end
        end else begin
            if (w_o_en) begin
                r_reg[r_tail]  <= w_o_reg;
                r_data[r_tail] <= w_o_data;
            end
            if (w_y_en) begin
                r_reg[w_o_en ? w_tail_p1 : r_tail]  <= w_y_reg;
                r_data[w_o_en ? w_tail_p1 : r_tail] <= w_y_data;
            end
        end
    end

    // Update the head, tail and occupancy. The readies keep the count within 0..DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq);
            r_tail  <= r_tail + w_enq_cnt[PW-1:0];
            r_count <= r_count + w_enq_cnt - CW'(w_deq);
        end
    end

    // Scan the valid entries from oldest to youngest, so the youngest match wins for bypass data.
    always_comb begin
        busy    = 16'd0;
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = 16'd0;
        q_data2 = 16'd0;
        w_idx   = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count) begin
                busy[r_reg[w_idx]] = 1'b1;
                if ((q_reg1 != 4'd0) && (r_reg[w_idx] == q_reg1)) begin
                    q_hit1  = 1'b1;
                    q_data1 = r_data[w_idx];
                end
                if ((q_reg2 != 4'd0) && (r_reg[w_idx] == q_reg2)) begin
                    q_hit2  = 1'b1;
                    q_data2 = r_data[w_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: bench for regfile_wb_ctrl.
// It runs directed scenarios and random traffic against a queue-based model.
// Define WB_RR_ARB_EN to select the round-robin model as well.
module tb_regfile_wb_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_reg;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_reg;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        wb_hold;
    logic [3:0]  rf_DstReg;
    logic        rf_WriteReg;
    logic [15:0] rf_DstData;
    logic [3:0]  q_reg1;
    logic [3:0]  q_reg2;
    logic        q_hit1;
    logic        q_hit2;
    logic [15:0] q_data1;
    logic [15:0] q_data2;
    logic [15:0] busy;
    logic        empty;

    // Each model entry holds {dst_reg, data}, with the oldest entry at index 0.
    logic [19:0] exp_q[$];
    bit          m_rr_mem;
    int          n_tests;
    int          n_fail;

    regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_hold(wb_hold),
        .rf_DstReg(rf_DstReg), .rf_WriteReg(rf_WriteReg), .rf_DstData(rf_DstData),
        .q_reg1(q_reg1), .q_reg2(q_reg2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_data1(q_data1), .q_data2(q_data2), .busy(busy), .empty(empty)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and check every output against the model.
    // After the rising edge, advance the model.
    task automatic step(input bit r,
                        input bit av, input logic [3:0] ar, input logic [15:0] ad,
                        input bit mv, input logic [3:0] mr, input logic [15:0] md,
                        input bit hold, input logic [3:0] q1, input logic [3:0] q2);
        int          free;
        bit          e_mr, e_ar, e_we, mem_first, mem_acc, alu_acc;
        logic [3:0]  e_dst;
        logic [15:0] e_dat, e_busy, e_d1, e_d2;
        bit          e_h1, e_h2;
        @(negedge clk);
        rst = r; alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        wb_hold = hold; q_reg1 = q1; q_reg2 = q2;
        if (!r) begin
            exp_q.delete();
            m_rr_mem = 1'b1;
        end
        #1;
        free = DEPTH - exp_q.size();
`ifdef WB_RR_ARB_EN
        e_mr = r && (free >= 2 || (free == 1 && (!av || m_rr_mem)));
        e_ar = r && (free >= 2 || (free == 1 && (!mv || !m_rr_mem)));
        mem_first = m_rr_mem;
`else
        e_mr = r && (free >= 1);
        e_ar = r && (free >= 2 || (free == 1 && !mv));
        mem_first = 1'b1;
`endif
        e_we  = r && (exp_q.size() > 0) && !hold;
        e_dst = e_we ? exp_q[0][19:16] : 4'd0;
        e_dat = e_we ? exp_q[0][15:0]  : 16'd0;
        e_busy = 16'd0; e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = 16'd0; e_d2 = 16'd0;
        foreach (exp_q[k]) begin
            e_busy[exp_q[k][19:16]] = 1'b1;
            if (q1 != 0 && exp_q[k][19:16] == q1) begin e_h1 = 1'b1; e_d1 = exp_q[k][15:0]; end
            if (q2 != 0 && exp_q[k][19:16] == q2) begin e_h2 = 1'b1; e_d2 = exp_q[k][15:0]; end
        end
        check_val("mem_ready", 32'(mem_ready), 32'(e_mr));
        check_val("alu_ready", 32'(alu_ready), 32'(e_ar));
        check_val("rf_WriteReg", 32'(rf_WriteReg), 32'(e_we));
        check_val("rf_DstReg", 32'(rf_DstReg), 32'(e_dst));
        check_val("rf_DstData", 32'(rf_DstData), 32'(e_dat));
        check_val("busy", 32'(busy), 32'(e_busy));
        check_val("q_hit1", 32'(q_hit1), 32'(e_h1));
        check_val("q_data1", 32'(q_data1), 32'(e_d1));
        check_val("q_hit2", 32'(q_hit2), 32'(e_h2));
        check_val("q_data2", 32'(q_data2), 32'(e_d2));
        check_val("empty", 32'(empty), 32'(exp_q.size() == 0));
        @(posedge clk);
        if (r) begin
            mem_acc = mv && e_mr;
            alu_acc = av && e_ar;
            if (e_we) void'(exp_q.pop_front());
            if (mem_first) begin
                if (mem_acc && mr != 0) exp_q.push_back({mr, md});
                if (alu_acc && ar != 0) exp_q.push_back({ar, ad});
            end else begin
                if (alu_acc && ar != 0) exp_q.push_back({ar, ad});
                if (mem_acc && mr != 0) exp_q.push_back({mr, md});
            end
`ifdef WB_RR_ARB_EN
            if (free == 1 && mv && av) m_rr_mem = !m_rr_mem;
`endif
        end
    endtask

    task automatic idle(input int n, input bit hold, input logic [3:0] q1, input logic [3:0] q2);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, hold, q1, q2);
    endtask

    // Stimulus: directed scenarios first, then random traffic
    initial begin
        n_tests = 0; n_fail = 0; m_rr_mem = 1'b1;
        rst = 1'b0; alu_valid = 0; alu_reg = 0; alu_data = 0;
        mem_valid = 0; mem_reg = 0; mem_data = 0; wb_hold = 0; q_reg1 = 0; q_reg2 = 0;

        // Reset: a request held during reset must see both readies at 0
        step(0, 1, 4'd3, 16'h1234, 1, 4'd2, 16'h4321, 0, 4'd3, 4'd2);
        step(0, 1, 4'd3, 16'h1234, 0, 0, 0, 0, 0, 0);

        // A single ALU write appears on the port the next cycle, and then the queue is empty
        step(1, 1, 4'd3, 16'h00A5, 0, 0, 0, 0, 4'd3, 0);
        idle(2, 0, 4'd3, 0);

        // While held, both sources fill the queue; after release it drains in mem-before-alu order
        for (int i = 0; i < 3; i++)
            step(1, 1, 4'(2 + 2 * (i % 2)), 16'(16'hA000 + i), 1, 4'(1 + 2 * (i % 2)), 16'(16'hB000 + i),
                 1, 4'd1, 4'd4);
        idle(5, 0, 4'd2, 4'd3);

        // Two queued writes to R5: the bypass returns the younger value, and a query of R0 never hits
        step(1, 1, 4'd5, 16'h0001, 0, 0, 0, 1, 4'd5, 0);
        step(1, 1, 4'd5, 16'h0002, 0, 0, 0, 1, 4'd5, 0);
        idle(1, 1, 4'd5, 0);
        idle(3, 0, 4'd5, 0);

        // A load write to R0 is accepted and discarded
        step(1, 0, 0, 0, 1, 4'd0, 16'hFFFF, 0, 0, 0);
        idle(1, 0, 0, 0);

        // Reset with three queued entries drops all of them
        for (int i = 0; i < 3; i++) step(1, 1, 4'(9 + i), 16'(16'hC000 + i), 0, 0, 0, 1, 4'd9, 4'd11);
        step(0, 0, 0, 0, 0, 0, 0, 1, 4'd9, 4'd11);
        idle(3, 0, 4'd9, 4'd11);

        // With one slot free, every cycle is a contested grant
        for (int i = 0; i < 3; i++) step(1, 1, 4'(6 + i), 16'(16'hD000 + i), 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++)
            step(1, 1, 4'd12, 16'(16'hE000 + i), 1, 4'd13, 16'(16'hF000 + i), 0, 4'd12, 4'd13);
        idle(5, 0, 4'd12, 4'd13);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), 16'($urandom),
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), 16'($urandom),
                 ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
